// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: IF/ID freeze/flush, PC load and imem request/ready handshake.
// Optional sticky fetch watchdog is built when FETCH_WATCHDOG_EN is defined.
module if_fetch_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic hazard,
  input  logic branch_taken,
  input  logic imem_ready,
  output logic imem_req,
  output logic pc_ld,
  output logic if_freeze,
  output logic if_flush
`ifdef FETCH_WATCHDOG_EN
  ,
  output logic fetch_timeout
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // Mealy decode; branch_taken outranks hazard in every state.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    pc_ld     = 1'b0;
    if_freeze = 1'b0;
    if_flush  = 1'b0;
    unique case (state)
      IDLE: begin
        if_flush  = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (branch_taken) begin
            if_flush = 1'b1;
            pc_ld    = 1'b1;
          end else if (hazard) begin
            if_freeze = 1'b1;
            state_nxt = HOLD;
          end else begin
            pc_ld = 1'b1;
          end
        end else begin
          if (branch_taken) begin
            if_flush  = 1'b1;
            pc_ld     = 1'b1;
            state_nxt = SQUASH;
          end else if (hazard) begin
            if_freeze = 1'b1;
          end else begin
            if_flush = 1'b1;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          if_flush  = 1'b1;
          pc_ld     = 1'b1;
          state_nxt = FETCH;
        end else if (hazard) begin
          if_freeze = 1'b1;
        end else begin
          pc_ld     = 1'b1;
          state_nxt = FETCH;
        end
      end
      SQUASH: begin
        // Wrong-path response is drained; hazard is irrelevant here.
        imem_req = 1'b1;
        if_flush = 1'b1;
        pc_ld    = branch_taken;
        if (imem_ready) state_nxt = FETCH;
      end
      default: begin
        if_flush  = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef FETCH_WATCHDOG_EN
  logic [CNT_W-1:0] wd_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wd_cnt        <= '0;
      fetch_timeout <= 1'b0;
    end else if (imem_req && !imem_ready) begin
      if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
      // Trip on the edge where the count becomes TIMEOUT.
      if (wd_cnt == CNT_W'(TIMEOUT - 1)) fetch_timeout <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      assert (TIMEOUT < (1 << CNT_W));
      assert (!(if_freeze && if_flush));
      assert (!(pc_ld && if_freeze));
    end
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch-stage sequencer that drives the freeze and flush controls of the IF/ID pipeline register and the PC load enable, and runs the request/ready handshake with a variable-latency instruction memory. It sits between the hazard detection unit (ID), the branch resolution logic (EXE) and the IF stage. It guarantees that no instruction is lost under a data hazard and that no wrong-path instruction enters ID after a taken branch, including branches that resolve while a fetch is outstanding.

## Interface
Parameters:
- TIMEOUT, 255, number of consecutive unanswered request cycles that trips the watchdog.
- CNT_W, 8, watchdog counter width; must satisfy TIMEOUT < 2^CNT_W.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- hazard  input  1  ID-stage data hazard; ID holds its instruction this cycle.
- branch_taken  input  1  EXE-stage taken branch; the external PC mux selects the target while this is high.
- imem_ready  input  1  instruction memory response valid.
- imem_req  output  1  fetch request; once raised it stays high until `imem_ready`.
- pc_ld  output  1  PC register load enable.
- if_freeze  output  1  IF/ID register hold.
- if_flush  output  1  IF/ID register clear (bubble insert).
- fetch_timeout  output  1  sticky watchdog error; only present with FETCH_WATCHDOG_EN.

## Operation
- States: IDLE, FETCH, HOLD, SQUASH. Outputs are Mealy: a function of the current state and the current inputs.
- Priority within any state: `branch_taken` > `hazard` > normal flow.
- The memory contract is that read data stays stable from `imem_ready` until the next request.

IDLE:
- Outputs: `imem_req`=0, `pc_ld`=0, `if_freeze`=0, `if_flush`=1.
- Goes to FETCH unconditionally on the next cycle.

FETCH (`imem_req`=1):
- `imem_ready` & `branch_taken`: `if_flush`=1, `pc_ld`=1, response discarded; stay in FETCH.
- `imem_ready` & `hazard`: `if_freeze`=1, `pc_ld`=0; go to HOLD.
- `imem_ready` alone: `pc_ld`=1, `if_freeze`=0, `if_flush`=0 (instruction captured); stay in FETCH.
- No `imem_ready` & `branch_taken`: `if_flush`=1, `pc_ld`=1; go to SQUASH.
- No `imem_ready` & `hazard`: `if_freeze`=1, `pc_ld`=0; stay in FETCH.
- No `imem_ready`, no other input: `if_flush`=1 (bubble), `pc_ld`=0; stay in FETCH.

HOLD (`imem_req`=0, memory data held):
- `branch_taken`: `if_flush`=1, `pc_ld`=1; go to FETCH.
- `hazard`: `if_freeze`=1, `pc_ld`=0; stay in HOLD.
- Otherwise: `pc_ld`=1, instruction captured; go to FETCH.

SQUASH (`imem_req`=1, the outstanding wrong-path fetch is drained):
- `if_flush`=1 every cycle.
- `pc_ld`=`branch_taken`, so a re-branch updates the target.
- `hazard` is ignored in this state.
- On `imem_ready`: the response is discarded and the state goes to FETCH.

General rules:
- `if_freeze` and `if_flush` are never high in the same cycle.
- `pc_ld` is never high while `if_freeze` is high.

## Timing
- Reset (`RST`=0, asynchronous):
  - State goes to IDLE.
  - Outputs: `imem_req`=0, `pc_ld`=0, `if_freeze`=0, `if_flush`=1, `fetch_timeout`=0.
  - The watchdog counter is cleared.
- After reset deasserts, the first `imem_req` appears in the second rising-edge cycle (IDLE lasts exactly 1 cycle).
- Zero-wait memory (`imem_ready` in the same cycle as `imem_req`): one instruction per cycle, `pc_ld`=1 every cycle.
- Branch latency:
  - The target is loaded in the same cycle `branch_taken` is seen.
  - In FETCH or HOLD, the first target fetch is requested the next cycle.
  - In SQUASH, the target fetch is requested the cycle after the drained `imem_ready`.
- Reset mid-fetch:
  - The request drops immediately (asynchronous).
  - The memory must abandon any in-flight access when `RST` is low.

## Configuration
- FETCH_WATCHDOG_EN defined:
  - A CNT_W-bit counter increments every cycle that `imem_req`=1 and `imem_ready`=0.
  - It clears on `imem_ready` and when `imem_req`=0, and saturates.
  - When the count reaches TIMEOUT, `fetch_timeout` is set and stays set until reset.
  - Watchdog trips have no effect on fetch sequencing.
- FETCH_WATCHDOG_EN undefined:
  - No counter is built.
  - The `fetch_timeout` port is absent.

## Test plan
- Reset release with `imem_ready` tied to 1, no hazards -> cycle 1 `if_flush`=1/`imem_req`=0; from cycle 2 `imem_req`=1, `pc_ld`=1 every cycle, `if_freeze`=`if_flush`=0.
- `imem_ready` delayed 3 cycles, no hazard -> 3 cycles of `if_flush`=1/`pc_ld`=0, then one `pc_ld`=1 capture cycle; the same pattern with `hazard`=1 gives `if_freeze`=1 instead of `if_flush`.
- `hazard` held for 4 cycles starting on the `imem_ready` cycle -> HOLD for 3 cycles with `imem_req`=0/`if_freeze`=1; on `hazard` fall `pc_ld`=1; next cycle `imem_req`=1.
- `branch_taken` 1 cycle during an outstanding fetch, `imem_ready` 2 cycles later -> `pc_ld`=1 on the branch cycle; `if_flush`=1 through the drained response; the next request follows in FETCH; no `pc_ld` capture from the discarded response.
- `branch_taken`=`hazard`=`imem_ready`=1 together -> `if_flush`=1, `pc_ld`=1, `if_freeze`=0, state stays FETCH.
- FETCH_WATCHDOG_EN with TIMEOUT=4, `imem_ready` held 0 -> `fetch_timeout` rises once 4 unanswered cycles are counted and stays 1 after `imem_ready` returns until `RST`=0; rebuilt without the macro, the sequencing matches exactly.
